dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory (256 × 32-bit, byte-addressed, word index = address[9:2], combinational read, posedge write) between the CPU load/store port and the FFT engine. The CPU issues single-beat accesses and the FFT engine issues bursts of up to MAX_BURST beats. Ties are resolved round-robin between CPU accesses and whole FFT bursts. A burst that has been granted keeps ownership until its last beat or until it is abandoned. The arbiter also blocks writes to addresses outside the memory and reports them through a sticky error flag.

## Interface
- DATA_W, 32, data width of all ports
- ADDR_W, 32, byte-address width
- IDX_W, 8, word-index bits; memory spans byte addresses 0 .. 4·2^IDX_W − 1
- MAX_BURST, 8, maximum FFT burst length in beats
- LEN_W, 4, width of fft_len
- clk  in  1  single clock, posedge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request, one beat
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle; CPU stalls while cpu_req=1 and cpu_gnt=0
- cpu_rdata  out  DATA_W  equals mem_rdata; valid only when cpu_gnt=1
- fft_req  in  1  FFT beat request; held high for the whole burst
- fft_we  in  1  FFT write / read for the current beat
- fft_addr  in  ADDR_W  FFT byte address for the current beat
- fft_wdata  in  DATA_W  FFT write data
- fft_len  in  LEN_W  burst length, sampled on the first beat only
- fft_gnt  out  1  FFT beat performed this cycle
- fft_last  out  1  granted beat is the final beat of the burst
- fft_rdata  out  DATA_W  equals mem_rdata; valid only when fft_gnt=1
- mem_we  out  1  to memory write_en
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write_DAT
- mem_rdata  in  DATA_W  from memory read_DAT
- busy  out  1  an FFT burst is in progress (burst_active)
- err_oor  out  1  sticky flag: a granted write was out of range

## Operation
- Registered state:
  - burst_active
  - beats_left (width $clog2(MAX_BURST+1))
  - last_owner (CPU/FFT)
  - err_oor
- Grant logic is combinational and evaluated every cycle:
  - fft_gnt = fft_req & (burst_active | ~cpu_req | last_owner==CPU)
  - cpu_gnt = cpu_req & ~fft_gnt
- Datapath mux: mem_addr, mem_wdata and the write enable come from the granted requester.
- With no grant, mem_addr = 0, mem_wdata = 0 and mem_we = 0.
- Effective length eff_len:
  - fft_len = 0 → 1
  - fft_len > MAX_BURST → MAX_BURST
  - otherwise fft_len
- First beat (fft_gnt & ~burst_active):
  - eff_len = 1 → fft_last = 1; no burst state is entered.
  - eff_len > 1 → burst_active ← 1 and beats_left ← eff_len − 1.
- Burst beat (fft_gnt & burst_active):
  - beats_left decrements.
  - When beats_left == 1, fft_last = 1 and burst_active ← 0 at the next edge.
- Abandoned burst (burst_active & ~fft_req):
  - No FFT beat is performed; the CPU may be granted in the same cycle.
  - burst_active ← 0 and beats_left ← 0 at the next edge.
  - last_owner ← FFT.
- last_owner update:
  - ← CPU on every cpu_gnt.
  - ← FFT on every FFT first beat.
- Range check: the address is out of range when addr[ADDR_W−1:IDX_W+2] ≠ 0.
  - A granted write to an out-of-range address is suppressed (mem_we = 0), and err_oor ← 1.
  - Out-of-range reads are passed through unchanged.
  - err_oor is cleared only by reset.
- Address bits [1:0] are ignored.

## Timing
- Reset (asynchronous):
  - burst_active = 0, beats_left = 0, last_owner = FFT, err_oor = 0.
  - Consequence: the CPU wins the first tie.
  - While reset is high: cpu_gnt, fft_gnt, fft_last and mem_we are forced to 0, and busy = 0.
- Latency is zero. The grant, memory address and read data all appear in the same cycle as the request. Write data is committed at the posedge that ends the granted cycle.
- A CPU request during an active burst waits until fft_last has been granted. The CPU is granted in the cycle after the last beat, even if fft_req remains high.
- Back-to-back FFT bursts with cpu_req held high alternate: FFT burst, CPU beat, FFT burst, and so on.
- Reset asserted mid-burst clears all state immediately. No partial write occurs after reset rises.
- Simultaneous first requests after reset: the CPU is granted; the FFT is granted the following cycle.

## Test plan
- Reset, then cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF → cpu_gnt=1 in the same cycle. Next cycle, a read of 0x10 returns cpu_rdata=0xDEADBEEF.
- fft_req=1, fft_len=4, writing addresses 0x00–0x0C, with cpu_req=1 from beat 2 → four consecutive fft_gnt with fft_last on beat 4, cpu_gnt=0 throughout, cpu_gnt=1 in cycle 5.
- Both requesting from reset, fft_len=2, fft_req held → grant order CPU, FFT, FFT(last), CPU, FFT, ...
- fft_len=0 → single beat with fft_last=1. fft_len=12 → exactly 8 beats, fft_last on beat 8.
- Burst of 4 with fft_req dropped after beat 2 → no beat 3. busy=0 the next cycle. A pending CPU request is granted in the drop cycle.
- CPU write to 0x400 → mem_we=0, memory unchanged, err_oor=1 and it stays 1. Async reset mid-burst (beat 2 of 6) → busy=0 and mem_we=0 immediately, err_oor=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// port (single beats) and the FFT engine (bursts of up to MAX_BURST beats).
// Ties alternate round-robin between CPU beats and whole FFT bursts. A granted
// burst owns the memory until its last beat or until fft_req drops. Writes
// outside the memory are suppressed and latched into a sticky error flag.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 8,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fft_req,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  input  logic [LEN_W-1:0]  fft_len,
  output logic              fft_gnt,
  output logic              fft_last,
  output logic [DATA_W-1:0] fft_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_oor
);

  localparam int BL_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_FFT = 1'b1
  } owner_t;

  // An address is out of range when any bit above the word index is set;
  // the two byte-offset bits are ignored.
  function automatic logic is_oor(input logic [ADDR_W-1:0] addr);
    return |addr[ADDR_W-1:IDX_W+2];
  endfunction

  logic              burst_active_r;
  logic [BL_W-1:0]   beats_left_r;
  owner_t            last_owner_r;
  logic              err_oor_r;

  logic [31:0]       len_ext_s;
  logic [BL_W-1:0]   eff_len_s;
  logic              first_beat_s;
  logic              burst_beat_s;
  logic              abandon_s;
  logic              req_we_s;
  logic              oor_write_s;

  assign len_ext_s = 32'(fft_len);

  // Clamp the requested burst length into 1 .. MAX_BURST.
  always_comb begin
    eff_len_s = BL_W'(1);
    if (len_ext_s == 32'd0) begin
      eff_len_s = BL_W'(1);
    end else if (len_ext_s > 32'(MAX_BURST)) begin
      eff_len_s = BL_W'(MAX_BURST);
    end else begin
      eff_len_s = BL_W'(len_ext_s);
    end
  end

  // Zero-latency grant: an active burst keeps the memory, otherwise the FFT
  // wins only when the CPU is idle or was the most recent owner.
  always_comb begin
    fft_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    fft_last = 1'b0;
    if (reset) begin
      fft_gnt  = 1'b0;
      cpu_gnt  = 1'b0;
      fft_last = 1'b0;
    end else begin
      fft_gnt  = fft_req & (burst_active_r | ~cpu_req | (last_owner_r == OWN_CPU));
      cpu_gnt  = cpu_req & ~fft_gnt;
      fft_last = fft_gnt & ((~burst_active_r & (eff_len_s == BL_W'(1))) |
                            (burst_active_r & (beats_left_r == BL_W'(1))));
    end
  end

  assign first_beat_s = fft_gnt & ~burst_active_r;
  assign burst_beat_s = fft_gnt & burst_active_r;
  assign abandon_s    = burst_active_r & ~fft_req;

  // Route the granted requester onto the memory bus; idle bus drives zeros.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    req_we_s  = 1'b0;
    if (fft_gnt) begin
      mem_addr  = fft_addr;
      mem_wdata = fft_wdata;
      req_we_s  = fft_we;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      req_we_s  = cpu_we;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      req_we_s  = 1'b0;
    end
  end

  assign oor_write_s = req_we_s & is_oor(mem_addr);
  assign mem_we      = req_we_s & ~is_oor(mem_addr);
  assign cpu_rdata   = mem_rdata;
  assign fft_rdata   = mem_rdata;
  assign busy        = burst_active_r;
  assign err_oor     = err_oor_r;

  // Burst tracking, round-robin owner history and sticky range error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_active_r <= 1'b0;
      beats_left_r   <= {BL_W{1'b0}};
      last_owner_r   <= OWN_FFT;
      err_oor_r      <= 1'b0;
    end else begin
      if (first_beat_s) begin
        last_owner_r <= OWN_FFT;
        if (eff_len_s > BL_W'(1)) begin
          burst_active_r <= 1'b1;
          beats_left_r   <= eff_len_s - BL_W'(1);
        end else begin
          burst_active_r <= 1'b0;
          beats_left_r   <= {BL_W{1'b0}};
        end
      end else if (burst_beat_s) begin
        beats_left_r <= beats_left_r - BL_W'(1);
        if (beats_left_r == BL_W'(1)) begin
          burst_active_r <= 1'b0;
        end else begin
          burst_active_r <= 1'b1;
        end
      end else if (abandon_s) begin
        burst_active_r <= 1'b0;
        beats_left_r   <= {BL_W{1'b0}};
        last_owner_r   <= OWN_FFT;
      end else begin
        burst_active_r <= burst_active_r;
        beats_left_r   <= beats_left_r;
      end
      // A CPU beat in the same cycle as an abandon still counts as the most
      // recent service, so the FFT wins the next tie.
      if (cpu_gnt) begin
        last_owner_r <= OWN_CPU;
      end else begin
        last_owner_r <= last_owner_r;
        if (first_beat_s | abandon_s) begin
          last_owner_r <= OWN_FFT;
        end else begin
          last_owner_r <= last_owner_r;
        end
      end
      if (oor_write_s) begin
        err_oor_r <= 1'b1;
      end else begin
        err_oor_r <= err_oor_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_gnt;
  logic        fft_req, fft_we;
  logic [31:0] fft_addr, fft_wdata, fft_rdata;
  logic [3:0]  fft_len;
  logic        fft_gnt, fft_last;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err_oor;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .fft_req(fft_req), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
    .fft_len(fft_len), .fft_gnt(fft_gnt), .fft_last(fft_last), .fft_rdata(fft_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err_oor(err_oor)
  );

  // Memory model: combinational read, posedge write.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    fft_req = 1'b0; fft_we = 1'b0; fft_addr = 32'h0; fft_wdata = 32'h0; fft_len = 4'd0;
  endtask

  task automatic cpu_set(input logic we, input logic [31:0] addr, input logic [31:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
  endtask

  task automatic fft_set(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] len);
    fft_req = 1'b1; fft_we = we; fft_addr = addr; fft_wdata = data; fft_len = len;
  endtask

  // Advance to the next negedge, apply inputs there, check 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  logic [5:0] exp_cpu_seq, exp_fft_seq, exp_last_seq;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    idle();
    reset = 1'b1;

    // Reset forces grants and write enable low even with requests present.
    step();
    cpu_set(1'b1, 32'h10, 32'h1111_1111);
    fft_set(1'b1, 32'h14, 32'h2222_2222, 4'd3);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 32'd0);
    chk("rst_fft_gnt", fft_gnt, 32'd0);
    chk("rst_fft_last", fft_last, 32'd0);
    chk("rst_mem_we", mem_we, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", err_oor, 32'd0);
    step();
    idle();
    reset = 1'b0;

    // CPU write then read back.
    step();
    cpu_set(1'b1, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("cpu_wr_gnt", cpu_gnt, 32'd1);
    chk("cpu_wr_we", mem_we, 32'd1);
    chk("cpu_wr_addr", mem_addr, 32'h10);
    step();
    cpu_set(1'b0, 32'h10, 32'h0);
    #1;
    chk("cpu_rd_gnt", cpu_gnt, 32'd1);
    chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);

    // Burst of 4 writes; CPU requests from beat 2 and must wait.
    for (int i = 0; i < 4; i++) begin
      step();
      idle();
      fft_set(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'd4);
      if (i >= 1) cpu_set(1'b0, 32'h10, 32'h0);
      #1;
      chk($sformatf("b4_gnt%0d", i), fft_gnt, 32'd1);
      chk($sformatf("b4_last%0d", i), fft_last, (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("b4_cpu%0d", i), cpu_gnt, 32'd0);
      chk($sformatf("b4_busy%0d", i), busy, (i > 0) ? 32'd1 : 32'd0);
    end
    step();
    cpu_set(1'b0, 32'h0C, 32'h0);
    fft_req = 1'b1;
    #1;
    chk("b4_cpu_after", cpu_gnt, 32'd1);
    chk("b4_fft_after", fft_gnt, 32'd0);
    chk("b4_rd_last", cpu_rdata, 32'hA3);
    chk("b4_busy_after", busy, 32'd0);

    // Simultaneous requests from reset, length 2: CPU, FFT, FFT(last), CPU, FFT, FFT(last).
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cpu_seq  = 6'b001001;
    exp_fft_seq  = 6'b110110;
    exp_last_seq = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      step();
      cpu_set(1'b0, 32'h10, 32'h0);
      fft_set(1'b0, 32'h0, 32'h0, 4'd2);
      #1;
      chk($sformatf("rr_cpu%0d", i), cpu_gnt, 32'(exp_cpu_seq[i]));
      chk($sformatf("rr_fft%0d", i), fft_gnt, 32'(exp_fft_seq[i]));
      chk($sformatf("rr_last%0d", i), fft_last, 32'(exp_last_seq[i]));
    end

    // Length 0 becomes a single beat.
    step();
    idle();
    fft_set(1'b0, 32'h0, 32'h0, 4'd0);
    #1;
    chk("len0_gnt", fft_gnt, 32'd1);
    chk("len0_last", fft_last, 32'd1);
    step();
    idle();
    #1;
    chk("len0_busy", busy, 32'd0);

    // Length 12 clamps to 8 beats.
    for (int i = 0; i < 8; i++) begin
      step();
      fft_set(1'b0, 32'(4 * i), 32'h0, 4'd12);
      #1;
      chk($sformatf("len12_gnt%0d", i), fft_gnt, 32'd1);
      chk($sformatf("len12_last%0d", i), fft_last, (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    idle();
    #1;
    chk("len12_busy_end", busy, 32'd0);
    chk("len12_gnt_end", fft_gnt, 32'd0);

    // Burst of 4 abandoned after beat 2; pending CPU served in the drop cycle.
    step();
    fft_set(1'b0, 32'h0, 32'h0, 4'd4);
    #1;
    chk("ab_beat1", fft_gnt, 32'd1);
    step();
    cpu_set(1'b0, 32'h10, 32'h0);
    #1;
    chk("ab_beat2", fft_gnt, 32'd1);
    chk("ab_cpu_wait", cpu_gnt, 32'd0);
    step();
    fft_req = 1'b0;
    #1;
    chk("ab_drop_fft", fft_gnt, 32'd0);
    chk("ab_drop_cpu", cpu_gnt, 32'd1);
    chk("ab_drop_data", cpu_rdata, 32'hDEAD_BEEF);
    step();
    idle();
    #1;
    chk("ab_busy", busy, 32'd0);

    // Range boundary: last in-range word writes, 0x400 is blocked.
    step();
    cpu_set(1'b1, 32'h3FC, 32'h0000_0055);
    #1;
    chk("oor_edge_we", mem_we, 32'd1);
    step();
    cpu_set(1'b1, 32'h400, 32'h1234_5678);
    #1;
    chk("oor_gnt", cpu_gnt, 32'd1);
    chk("oor_we", mem_we, 32'd0);
    chk("oor_err_pre", err_oor, 32'd0);
    step();
    cpu_set(1'b0, 32'h0, 32'h0);
    #1;
    chk("oor_mem0", cpu_rdata, 32'hA0);
    chk("oor_err", err_oor, 32'd1);
    step();
    cpu_set(1'b0, 32'h3FC, 32'h0);
    #1;
    chk("oor_edge_rd", cpu_rdata, 32'h55);
    chk("oor_err_sticky", err_oor, 32'd1);

    // Async reset during beat 2 of a 6-beat write burst.
    step();
    idle();
    fft_set(1'b1, 32'h20, 32'hC0C0_0001, 4'd6);
    #1;
    chk("rmb_beat1", fft_gnt, 32'd1);
    step();
    fft_set(1'b1, 32'h24, 32'hC0C0_0002, 4'd6);
    #1;
    chk("rmb_beat2", fft_gnt, 32'd1);
    chk("rmb_busy_pre", busy, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rmb_busy", busy, 32'd0);
    chk("rmb_we", mem_we, 32'd0);
    chk("rmb_gnt", fft_gnt, 32'd0);
    chk("rmb_err", err_oor, 32'd0);
    step();
    idle();
    reset = 1'b0;
    step();
    cpu_set(1'b0, 32'h24, 32'h0);
    #1;
    chk("rmb_no_write", cpu_rdata, 32'h0);
    step();
    cpu_set(1'b0, 32'h20, 32'h0);
    #1;
    chk("rmb_beat1_kept", cpu_rdata, 32'hC0C0_0001);

    step();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
